// File: rtl/if_prefetch.sv
// Instruction-fetch stage: one outstanding sequential read, DEPTH-entry prefetch queue, redirect flush.
// Define IF_EARLY_HOLD_EN to stall prefetch behind fetched JAL/JALR/BRANCH words until resolve or missed.
//
// state | meaning
// IDLE  | no read outstanding; request when the queue has room and no hold
// REQ   | mem_req raised, waiting for the controller to accept
// WAIT  | read accepted, data will be enqueued on mem_done
// DROP  | read accepted before a redirect, data discarded on mem_done
module if_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rdy_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_busy_i,
    input  logic            mem_done_i,
    input  logic [31:0]     mem_rdata_i,
    input  logic            missed_i,
    input  logic [XLEN-1:0] new_pc_i,
    input  logic            resolve_i,
    input  logic            id_ready_i,
    output logic            if_valid_o,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            stallreq_o,
    output logic            ctrl_hold_o
);

    localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]      instr_q [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ctrl_hold_q, ctrl_hold_d;

    logic accept;
    logic in_wait;
    logic room;
    logic fetch_go;
    logic enq;
    logic deq;

    always_comb begin
        accept   = mem_req_q && !mem_busy_i;
        in_wait  = (state_q == S_WAIT);
        room     = (count_q + CNT_W'(in_wait)) < DEPTH_C;
        fetch_go = room && !ctrl_hold_q && !missed_i;
        enq      = in_wait && mem_done_i && !missed_i;
        deq      = if_valid_o && id_ready_i && !missed_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else if (rdy_i) begin
            state_q <= state_d;
        end
    end

    // A redirect never starts a request; an accepted or in-flight read must still be retired.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_go) state_d = S_REQ;
            end
            S_REQ: begin
                if (accept)        state_d = missed_i ? S_DROP : S_WAIT;
                else if (missed_i) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (mem_done_i)    state_d = S_IDLE;
                else if (missed_i) state_d = S_DROP;
            end
            S_DROP: begin
                if (mem_done_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = mem_req_q;
        mem_addr_o  = mem_addr_q;
        if_valid_o  = (count_q != '0);
        stallreq_o  = (count_q == '0);
        if_instr_o  = instr_q[head_q];
        if_pc_o     = pc_q[head_q];
        ctrl_hold_o = ctrl_hold_q;
    end

    always_comb begin
        mem_req_d  = (state_d == S_REQ);
        mem_addr_d = mem_addr_q;
        if (state_q == S_IDLE && state_d == S_REQ) begin
            mem_addr_d = fetch_pc_q;
        end

        fetch_pc_d = fetch_pc_q;
        if (missed_i) begin
            fetch_pc_d = new_pc_i;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (missed_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef IF_EARLY_HOLD_EN
    always_comb begin
        ctrl_hold_d = ctrl_hold_q;
        if (missed_i) begin
            ctrl_hold_d = 1'b0;
        end else if (enq && (mem_rdata_i[6:4] == 3'b110)) begin
            ctrl_hold_d = 1'b1;
        end else if (resolve_i) begin
            ctrl_hold_d = 1'b0;
        end
    end
`else
    logic unused_resolve;
    assign unused_resolve = resolve_i;

    always_comb begin
        ctrl_hold_d = 1'b0;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ctrl_hold_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (rdy_i) begin
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ctrl_hold_q <= ctrl_hold_d;
            if (enq) begin
                instr_q[tail_q] <= mem_rdata_i;
                pc_q[tail_q]    <= mem_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch queue.
module tb_if_prefetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef IF_EARLY_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rdy = 1'b1, mem_busy = 1'b0, mem_done = 1'b0;
    logic        missed = 1'b0, resolve = 1'b0, id_ready = 1'b0;
    logic [31:0] mem_rdata = '0, new_pc = '0;
    logic        mem_req, if_valid, stallreq, ctrl_hold;
    logic [31:0] mem_addr, if_instr, if_pc;

    if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_busy_i(mem_busy),
        .mem_done_i(mem_done), .mem_rdata_i(mem_rdata),
        .missed_i(missed), .new_pc_i(new_pc), .resolve_i(resolve), .id_ready_i(id_ready),
        .if_valid_o(if_valid), .if_instr_o(if_instr), .if_pc_o(if_pc),
        .stallreq_o(stallreq), .ctrl_hold_o(ctrl_hold)
    );

    int vectors = 0;
    int miscompares = 0;

    int p_busy, p_rdy_low, p_miss, p_resolve, p_ready, lat_min, lat_max;
    bit          force_miss = 1'b0;
    logic [31:0] force_pc = '0;

    bit          resp_busy = 1'b0, pend_acc = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] resp_addr = '0, pend_addr = '0;
    logic [31:0] acc_log[$];
    logic [31:0] deq_log[$];

    // Memory image: address-derived words, with a BRANCH opcode at offsets 0x34 mod 0x80.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [6:0] op;
        op = (a[6:2] == 5'd13) ? 7'b1100011 : 7'b0010011;
        return {a[31:7] ^ 25'h0A5A5A5, op};
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if (r[10:8] == 3'd0) return 32'hFFFF_FFF0 | (r & 32'h0000_000C);
        return r & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_acc(input int idx, input logic [31:0] exp);
        if (idx < acc_log.size()) check($sformatf("req_addr[%0d]", idx), acc_log[idx], exp);
        else begin
            vectors++;
            miscompares++;
            $display("FAIL req_addr[%0d]: no request seen, expected=%h", idx, exp);
        end
    endtask

    task automatic check_deq(input int idx, input logic [31:0] exp);
        if (idx < deq_log.size()) check($sformatf("deq_pc[%0d]", idx), deq_log[idx], exp);
        else begin
            vectors++;
            miscompares++;
            $display("FAIL deq_pc[%0d]: no dequeue seen, expected=%h", idx, exp);
        end
    endtask

    // Reference model: pending request, one read in flight (possibly doomed), queue of {pc, instr}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    bit          m_req = 1'b0, m_infl = 1'b0, m_disc = 1'b0, m_hold = 1'b0;
    logic [31:0] m_addr = '0, m_fpc = '0;
    ent_t        mq[$];

    always @(posedge clk) begin : model
        bit          o_req, o_infl, o_hold, o_idle, deq, enq_ctrl;
        int          o_cnt;
        logic [31:0] o_fpc;
        ent_t        e;
        if (rst) begin
            m_req = 1'b0; m_infl = 1'b0; m_disc = 1'b0; m_hold = 1'b0;
            m_addr = '0; m_fpc = 32'h0;
            mq.delete();
        end else if (rdy) begin
            o_req = m_req; o_infl = m_infl; o_hold = m_hold; o_fpc = m_fpc; o_cnt = mq.size();
            o_idle   = !o_req && !o_infl;
            deq      = (o_cnt > 0) && id_ready && !missed;
            enq_ctrl = 1'b0;
            if (o_infl && mem_done) begin
                if (!m_disc && !missed) begin
                    e.pc = m_addr;
                    e.instr = mem_rdata;
                    mq.push_back(e);
                    enq_ctrl = (mem_rdata[6:4] == 3'b110);
                end
                m_infl = 1'b0;
                m_disc = 1'b0;
            end else if (o_infl && missed) begin
                m_disc = 1'b1;
            end
            if (o_req && !mem_busy) begin
                m_req = 1'b0; m_infl = 1'b1; m_disc = missed; m_fpc = o_fpc + 32'd4;
            end else if (o_req && missed) begin
                m_req = 1'b0;
            end
            if (deq) void'(mq.pop_front());
            if (missed) begin
                mq.delete();
                m_fpc = new_pc;
                m_hold = 1'b0;
            end else if (HOLD_EN && enq_ctrl) begin
                m_hold = 1'b1;
            end else if (HOLD_EN && resolve) begin
                m_hold = 1'b0;
            end
            if (o_idle && !missed && o_cnt < DEPTH && !o_hold) begin
                m_req = 1'b1;
                m_addr = o_fpc;
            end
        end
    end

    task automatic compare_model();
        check("mem_req", mem_req, m_req);
        if (m_req) check("mem_addr", mem_addr, m_addr);
        check("if_valid", if_valid, mq.size() != 0);
        check("stallreq", stallreq, mq.size() == 0);
        check("ctrl_hold", ctrl_hold, m_hold);
        if (mq.size() != 0) begin
            check("if_pc", if_pc, mq[0].pc);
            check("if_instr", if_instr, mq[0].instr);
        end
    endtask

    // One cycle: compare at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input bit do_rst);
        @(negedge clk);
        compare_model();
        if (pend_acc) begin
            resp_busy = 1'b1;
            resp_addr = pend_addr;
            resp_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        pend_acc = 1'b0;
        if (do_rst) resp_busy = 1'b0;
        rst = do_rst;
        rdy = do_rst ? 1'b1 : (int'($urandom_range(99, 0)) >= p_rdy_low);
        mem_done  = 1'b0;
        mem_rdata = $urandom;
        if (resp_busy && rdy && !do_rst) begin
            if (resp_cnt == 0) begin
                mem_done  = 1'b1;
                mem_rdata = word_of(resp_addr);
                resp_busy = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
        mem_busy = int'($urandom_range(99, 0)) < p_busy;
        id_ready = int'($urandom_range(99, 0)) < p_ready;
        resolve  = int'($urandom_range(99, 0)) < p_resolve;
        missed   = force_miss || (int'($urandom_range(99, 0)) < p_miss);
        new_pc   = force_miss ? force_pc : rand_pc();
        force_miss = 1'b0;
        if (!do_rst && rdy) begin
            if (mem_req && !mem_busy) begin
                pend_acc  = 1'b1;
                pend_addr = mem_addr;
                acc_log.push_back(mem_addr);
            end
            if (if_valid && id_ready && !missed) deq_log.push_back(if_pc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic quiet(input int lat);
        p_busy = 0; p_rdy_low = 0; p_miss = 0; p_resolve = 0; p_ready = 100;
        lat_min = lat; lat_max = lat;
    endtask

    task automatic do_reset();
        step(1'b1);
        step(1'b1);
        acc_log.delete();
        deq_log.delete();
    endtask

    initial begin
        int guard;

        // Reset values, first request one cycle after reset, in-order fetch with latency 2.
        quiet(2);
        do_reset();
        step(1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_stallreq", stallreq, 1'b1);
        check("rst_ctrl_hold", ctrl_hold, 1'b0);
        step(1'b0);
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 32'h0);
        run(20);
        check_acc(0, 32'h0); check_acc(1, 32'h4); check_acc(2, 32'h8);
        check_deq(0, 32'h0); check_deq(1, 32'h4); check_deq(2, 32'h8);

        // Decode stalled: exactly DEPTH reads, then drain and resume at 0x10.
        quiet(2);
        lat_min = 1; lat_max = 3; p_ready = 0;
        do_reset();
        run(40);
        check("reads_while_stalled", acc_log.size(), 32'd4);
        check_acc(3, 32'hC);
        p_ready = 100;
        run(30);
        check_deq(0, 32'h0); check_deq(1, 32'h4); check_deq(2, 32'h8); check_deq(3, 32'hC);
        check_acc(4, 32'h10);

        // Redirect while waiting on the read of 0x8.
        quiet(6);
        do_reset();
        guard = 0;
        while (acc_log.size() < 3 && guard < 80) begin
            step(1'b0);
            guard++;
        end
        check_acc(2, 32'h8);
        force_miss = 1'b1;
        force_pc   = 32'h100;
        step(1'b0);
        acc_log.delete();
        deq_log.delete();
        step(1'b0);
        check("flush_empty", if_valid, 1'b0);
        run(40);
        check_acc(0, 32'h100);
        check_deq(0, 32'h100);

        // Redirect coinciding with mem_done and a dequeue-ready valid head.
        quiet(2);
        p_ready = 0;
        do_reset();
        guard = 0;
        while (acc_log.size() < 2 && guard < 40) begin
            step(1'b0);
            guard++;
        end
        step(1'b0);
        check("head_before_miss", if_valid, 1'b1);
        force_miss = 1'b1;
        force_pc   = 32'h200;
        p_ready    = 100;
        step(1'b0);
        step(1'b0);
        check("miss_done_valid", if_valid, 1'b0);
        check("miss_done_idle", mem_req, 1'b0);
        step(1'b0);
        check("miss_done_req", mem_req, 1'b1);
        check("miss_done_addr", mem_addr, 32'h200);

        // Address wrap from 0xFFFF_FFFC, redirect landing on an accepted request.
        quiet(1);
        do_reset();
        step(1'b0);
        force_miss = 1'b1;
        force_pc   = 32'hFFFF_FFFC;
        step(1'b0);
        acc_log.delete();
        deq_log.delete();
        run(20);
        check_acc(0, 32'hFFFF_FFFC); check_acc(1, 32'h0);
        check_deq(0, 32'hFFFF_FFFC); check_deq(1, 32'h0);

        // Randomized traffic against the model.
        quiet(1);
        p_busy = 30; p_rdy_low = 10; p_miss = 4; p_resolve = 10; p_ready = 60;
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(int'($urandom_range(999, 0)) < 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
